// File: rtl/ga23_pkg.sv
// rtl/ga23_pkg.sv - shared types and constants for the GA23 tile fetch scheduler
package ga23_pkg;

    localparam int NUM_LAYERS = 3;
    localparam int NUM_COLS   = 42;
    localparam int VRAM_AW    = 15;
    localparam int ROM_AW     = 19;
    localparam int LW         = 2;

    typedef struct packed {
        logic [15:0] code;
        logic [6:0]  palette;
        logic        flip_x;
        logic        flip_y;
        logic [1:0]  prio;
    } tile_attr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTR_REQ,
        ST_ROM_REQ,
        ST_NEXT,
        ST_WAIT_EDGE
    } fetch_state_t;

    // Lowest enabled layer at or above 'from'; MSB flags that one was found.
    function automatic logic [LW:0] pick_layer(input logic [NUM_LAYERS-1:0] en,
                                               input logic [LW-1:0] from);
        logic [LW:0] r;
        r = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (en[i] && (i >= int'(from)))
                r = {1'b1, LW'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/ga23_tile_addr.sv
// rtl/ga23_tile_addr.sv - scroll wrap and VRAM/ROM address generation for one layer
module ga23_tile_addr
    import ga23_pkg::*;
(
    input  logic [5:0]         col,
    input  logic [8:0]         vcount,
    input  logic [9:0]         scroll_x,
    input  logic [9:0]         scroll_y,
    input  logic [2:0]         base,
    input  logic [15:0]        code,
    input  logic               flip_y,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [ROM_AW-1:0]  rom_addr
);

    logic [9:0] x;
    logic [9:0] y;
    logic       unused_bits;

    // Both sums wrap at 1024; the map only sees the 64-entry window [8:3].
    always_comb begin
        x         = {1'b0, col, 3'b000} + scroll_x;
        y         = {1'b0, vcount} + scroll_y;
        vram_addr = {base, y[8:3], x[8:3]};
        rom_addr  = {code, y[2:0] ^ {3{flip_y}}};
    end

    assign unused_bits = ^{x[9], x[2:0], y[9]};

endmodule

// File: rtl/ga23_fetch_sched.sv
// rtl/ga23_fetch_sched.sv - per-column attribute/ROM fetch sequencer feeding the tile shifters
module ga23_fetch_sched
    import ga23_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce_pix,
    input  logic                             line_start,
    input  logic [8:0]                       vcount,
    input  logic [NUM_LAYERS-1:0]            layer_en,
    input  logic [NUM_LAYERS-1:0][2:0]       layer_base,
    input  logic [NUM_LAYERS-1:0][9:0]       scroll_x,
    input  logic [NUM_LAYERS-1:0][9:0]       scroll_y,
    output logic                             vram_req,
    output logic [VRAM_AW-1:0]               vram_addr,
    input  logic                             vram_ack,
    input  logic [31:0]                      vram_data,
    output logic                             rom_req,
    output logic [ROM_AW-1:0]                rom_addr,
    input  logic                             rom_ack,
    input  logic [31:0]                      rom_data,
    output logic [NUM_LAYERS-1:0]            load,
    output logic [NUM_LAYERS-1:0][31:0]      row,
    output logic [NUM_LAYERS-1:0][6:0]       palette,
    output logic [NUM_LAYERS-1:0][1:0]       prio,
    output logic [NUM_LAYERS-1:0]            reverse,
    output logic [NUM_LAYERS-1:0][2:0]       offset,
    output logic                             overrun
);

    fetch_state_t                     state;
    logic [5:0]                       col;
    logic [2:0]                       sub;
    logic [LW-1:0]                    layer;
    logic [NUM_LAYERS-1:0]            ready;
    logic [NUM_LAYERS-1:0]            en_l;
    logic [8:0]                       vcount_l;
    logic [NUM_LAYERS-1:0][9:0]       sx_l;
    logic [NUM_LAYERS-1:0][9:0]       sy_l;
    logic [NUM_LAYERS-1:0][2:0]       base_l;
    tile_attr_t                       cur_attr;
    tile_attr_t [NUM_LAYERS-1:0]      stage_attr;
    logic [NUM_LAYERS-1:0][31:0]      stage_row;

    tile_attr_t                       vram_attr;
    logic                             unused_vram_bits;
    logic [VRAM_AW-1:0]               addr_vram;
    logic [ROM_AW-1:0]                addr_rom;
    logic [LW:0]                      start_pick;
    logic [LW:0]                      first_pick;
    logic [LW:0]                      next_pick;
    logic                             col_edge;

    assign vram_attr = '{code:    vram_data[15:0],
                         palette: vram_data[22:16],
                         flip_x:  vram_data[25],
                         flip_y:  vram_data[26],
                         prio:    vram_data[29:28]};
    assign unused_vram_bits = ^{vram_data[31:30], vram_data[27], vram_data[24:23]};

    assign col_edge   = ce_pix && (sub == 3'd7);
    assign start_pick = pick_layer(layer_en, '0);
    assign first_pick = pick_layer(en_l, '0);
    assign next_pick  = pick_layer(en_l, layer + 1'b1);

    ga23_tile_addr u_addr (
        .col       (col),
        .vcount    (vcount_l),
        .scroll_x  (sx_l[layer]),
        .scroll_y  (sy_l[layer]),
        .base      (base_l[layer]),
        .code      (cur_attr.code),
        .flip_y    (cur_attr.flip_y),
        .vram_addr (addr_vram),
        .rom_addr  (addr_rom)
    );

    always_ff @(posedge clk) begin
        load <= '0;
        if (reset) begin
            state      <= ST_IDLE;
            col        <= '0;
            sub        <= '0;
            layer      <= '0;
            ready      <= '0;
            en_l       <= '0;
            vcount_l   <= '0;
            sx_l       <= '0;
            sy_l       <= '0;
            base_l     <= '0;
            cur_attr   <= '0;
            stage_attr <= '0;
            stage_row  <= '0;
            vram_req   <= 1'b0;
            vram_addr  <= '0;
            rom_req    <= 1'b0;
            rom_addr   <= '0;
            row        <= '0;
            palette    <= '0;
            prio       <= '0;
            reverse    <= '0;
            offset     <= '0;
            overrun    <= 1'b0;
        end else if (line_start) begin
            vcount_l <= vcount;
            sx_l     <= scroll_x;
            sy_l     <= scroll_y;
            base_l   <= layer_base;
            en_l     <= layer_en;
            for (int i = 0; i < NUM_LAYERS; i++)
                offset[i] <= scroll_x[i][2:0];
            col      <= '0;
            sub      <= '0;
            layer    <= start_pick[LW-1:0];
            ready    <= ~layer_en;
            vram_req <= 1'b0;
            rom_req  <= 1'b0;
            state    <= start_pick[LW] ? ST_ATTR_REQ : ST_WAIT_EDGE;
        end else begin
            if (ce_pix)
                sub <= sub + 3'd1;
            // The column edge wins over any handshake: unfinished layers go out transparent.
            if (col_edge && state != ST_IDLE) begin
                load <= '1;
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    if (ready[i] && en_l[i]) begin
                        row[i]     <= stage_row[i];
                        palette[i] <= stage_attr[i].palette;
                        prio[i]    <= stage_attr[i].prio;
                        reverse[i] <= stage_attr[i].flip_x;
                    end else begin
                        row[i]     <= '0;
                        palette[i] <= '0;
                        prio[i]    <= '0;
                        reverse[i] <= 1'b0;
                    end
                end
                if (!(&ready))
                    overrun <= 1'b1;
                vram_req <= 1'b0;
                rom_req  <= 1'b0;
                if (col == 6'(NUM_COLS - 1)) begin
                    state <= ST_IDLE;
                end else begin
                    col   <= col + 6'd1;
                    layer <= first_pick[LW-1:0];
                    ready <= ~en_l;
                    state <= first_pick[LW] ? ST_ATTR_REQ : ST_WAIT_EDGE;
                end
            end else begin
                case (state)
                    ST_ATTR_REQ: begin
                        if (!vram_req) begin
                            vram_req  <= 1'b1;
                            vram_addr <= addr_vram;
                        end else if (vram_ack) begin
                            vram_req <= 1'b0;
                            cur_attr <= vram_attr;
                            state    <= ST_ROM_REQ;
                        end
                    end
                    ST_ROM_REQ: begin
                        if (!rom_req) begin
                            rom_req  <= 1'b1;
                            rom_addr <= addr_rom;
                        end else if (rom_ack) begin
                            rom_req           <= 1'b0;
                            stage_row[layer]  <= rom_data;
                            stage_attr[layer] <= cur_attr;
                            ready[layer]      <= 1'b1;
                            state             <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (next_pick[LW]) begin
                            layer <= next_pick[LW-1:0];
                            state <= ST_ATTR_REQ;
                        end else begin
                            state <= ST_WAIT_EDGE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
